fir_ntap_prog: RTL and testbench
================================

Name: fir_ntap_prog

Overview:
- Parametrised N-tap, w-bit signed, direct-form FIR filter with runtime-programmable coefficients.
- Next generation of the fixed 4-tap averaging FIR. With default parameters and reset coefficients it reproduces that filter's unscaled 4-sample sum.
- Adds a sample-valid qualifier, a double-buffered coefficient bank, a synchronous flush, and optional round/saturate output scaling.
- Sits in the datapath between a sample source and downstream scaling or decimation.

Parameters:
- w, 16: input sample width, two's complement.
- TAPS, 4: number of taps; must be ≥2.
- CW, 16: coefficient width, two's complement.
- SW, w+CW+$clog2(TAPS): output width. Derived localparam; the sum is full precision and cannot overflow.
- SHIFT, 2: right-shift applied when FIR_SAT_EN is defined; must be ≥0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of delay line and valid pipe.
- in_valid  in  1  qualifies a.
- a  in  w  signed input sample.
- coef_we  in  1  write shadow coefficient.
- coef_idx  in  $clog2(TAPS)  shadow coefficient index.
- coef_data  in  CW  signed coefficient value.
- coef_commit  in  1  copy shadow bank to active bank.
- out_valid  out  1  s carries a new result.
- s  out  SW  signed filter output.
- sat  out  1  saturation flag; tied 0 when FIR_SAT_EN is undefined.

Behaviour:
- Reset (asynchronous, active-high):
  - Delay line x[0..TAPS-1] = 0.
  - Valid pipe = 0, out_valid = 0, s = 0, sat = 0.
  - Shadow and active coefficients all = 1.
- Delay line:
  - On an edge with in_valid=1: x[0] ← a and x[k] ← x[k-1].
  - With in_valid=0 the line holds. Gaps never insert zeros.
- Stage 2:
  - At each edge: s ← Σ c_act[k]·x[k] for k=0..TAPS-1, sign-extended to SW. Products are summed via an adder tree.
  - s is updated only when the stage-1 valid bit v1 is 1; otherwise s holds its value.
  - out_valid ← v1, and v1 ← in_valid.
- Latency:
  - A sample presented with in_valid in cycle n produces its result on s with out_valid=1 in cycle n+2.
  - out_valid is high for exactly one cycle per accepted sample. Back-to-back inputs give back-to-back outputs.
- Coefficients:
  - coef_we writes shadow[coef_idx] ← coef_data.
  - An index ≥TAPS is ignored.
  - coef_commit copies all shadow values into the active bank at the edge.
  - Same-cycle coef_we and coef_commit: the committed bank includes the new write (bypass).
  - The active bank is used by stage 2. An edge with commit still computes with the old active values; the following edges use the new ones.
- Flush:
  - Clears x[] and v1; out_valid=0 in the next cycle.
  - s and both coefficient banks are retained.
  - flush takes priority over a same-cycle in_valid, so that sample is dropped.
- Reset mid-stream: everything returns to reset values, including coefficients = 1. No output is produced for in-flight samples.
- No backpressure: the block accepts a sample every cycle.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined:
  - Stage 2 computes r = (sum + 2^(SHIFT-1)) >>> SHIFT, using round-half-up; with SHIFT=0 there is no rounding add.
  - r is clamped to [-2^(w-1), 2^(w-1)-1] and sign-extended into s.
  - sat=1 for the output cycle in which clamping occurred, else 0. sat registers alongside s.
- Undefined: s is the full-precision sum and sat is constant 0.

Decomposition:
- Package fir_pkg holds:
  - Default constants FIR_W, FIR_TAPS, FIR_CW, FIR_SHIFT.
  - Function sw_calc(w, cw, taps) returning the output width.
  - Function sat_round(), used by the optional path.
- One sub-module, fir_coef_bank: the shadow/active registers with write, commit and bypass. It outputs the active coefficient vector.
- Delay line and adder tree stay in the top module.

Test Plan:
- Default coefficients, TAPS=4, w=16, inputs 1,2,3,4,5 with in_valid every cycle → s = 1,3,6,10,14 with out_valid, each 2 cycles after its input.
- Load coefficients [2,-1,0,3], commit, then impulse 1 followed by zeros → s = 2,-1,0,3,0.
- Extremes (w=CW=16): all coefficients -32768, four inputs of -32768 → s = 2^32 (SW=34), no wrap.
- Gapped valid: inputs 1,2,3 with in_valid=0 cycles between → s = 1,3,6. out_valid stays low during gaps and s holds.
- Flush after inputs 7,7 (all coefficients 1) → the next input 1 gives s=1.
  - Assert async reset mid-stream → out_valid=0 and s=0 immediately, and coefficients return to 1.
- FIR_SAT_EN with SHIFT=2:
  - Coefficients 1, four inputs of 32767 → s=32767, sat=0.
  - Coefficients 4 → s=32767, sat=1.
  - Coefficients 4, four inputs of -32768 → s=-32768, sat=1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults, output-width helper and the round/saturate helper used by
// the optional FIR_SAT_EN output path of fir_ntap_prog.
package fir_pkg;

  localparam int FIR_W     = 16;
  localparam int FIR_TAPS  = 4;
  localparam int FIR_CW    = 16;
  localparam int FIR_SHIFT = 2;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } rnd_t;

  function automatic int sw_calc(input int w, input int cw, input int taps);
    return w + cw + $clog2(taps);
  endfunction

  // Round half up, arithmetic shift, then clamp to a w-bit signed range.
  function automatic rnd_t sat_round(input logic signed [63:0] sum,
                                     input int shift, input int w);
    logic signed [63:0] biased;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd_t res;
    biased  = (shift > 0) ? sum + (64'sd1 <<< (shift - 1)) : sum;
    r       = biased >>> shift;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w - 1));
    res.val = r;
    res.sat = 1'b0;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient bank: shadow writes, commit to active, with
// a same-cycle write folded into the committed bank.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int CW   = FIR_CW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_idx,
  input  logic [CW-1:0]                 coef_data,
  input  logic                          coef_commit,
  output logic [TAPS-1:0][CW-1:0]       coef_act_o
);

  logic [TAPS-1:0][CW-1:0] shadow_q, shadow_d;
  logic [TAPS-1:0][CW-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (coef_we && (int'(coef_idx) < TAPS)) begin
      shadow_d[coef_idx] = coef_data;
    end
    active_d = coef_commit ? shadow_d : active_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= CW'(1);
        active_q[k] <= CW'(1);
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign coef_act_o = active_q;

endmodule

// File: rtl/fir_ntap_prog.sv
// N-tap programmable direct-form FIR, two-stage pipeline (delay line, MAC tree).
// Define FIR_SAT_EN for round/shift/saturate output scaling with a sat flag.
module fir_ntap_prog
  import fir_pkg::*;
#(
  parameter  int w     = FIR_W,
  parameter  int TAPS  = FIR_TAPS,
  parameter  int CW    = FIR_CW,
  parameter  int SHIFT = FIR_SHIFT,
  localparam int SW    = sw_calc(w, CW, TAPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [w-1:0]            a,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_idx,
  input  logic [CW-1:0]           coef_data,
  input  logic                    coef_commit,
  output logic                    out_valid,
  output logic signed [SW-1:0]    s,
  output logic                    sat
);

  if (TAPS < 2 || SHIFT < 0) begin : g_param_check
    $error("fir_ntap_prog: TAPS must be >= 2 and SHIFT >= 0");
  end

  logic [TAPS-1:0][CW-1:0] c_act;
  logic [TAPS-1:0][w-1:0]  x_q, x_d;
  logic                    v1_q, v1_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [SW-1:0]    s_q, s_d;
  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    tree [TAPS];

  fir_coef_bank #(.TAPS(TAPS), .CW(CW)) u_coef_bank (
    .clk         (clk),
    .reset       (reset),
    .coef_we     (coef_we),
    .coef_idx    (coef_idx),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .coef_act_o  (c_act)
  );

  // Pairwise reduction: level with stride `step` folds tree[k+step] into tree[k].
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      tree[k] = SW'($signed(x_q[k]) * $signed(c_act[k]));
    end
    for (int step = 1; step < TAPS; step = step * 2) begin
      for (int k = 0; k + step < TAPS; k = k + 2 * step) begin
        tree[k] = tree[k] + tree[k + step];
      end
    end
    sum = tree[0];
  end

`ifdef FIR_SAT_EN
  logic sat_q, sat_d;
  rnd_t rnd;

  always_comb rnd = sat_round(64'(sum), SHIFT, w);
`endif

  always_comb begin
    x_d         = x_q;
    v1_d        = in_valid;
    out_valid_d = v1_q;
    s_d         = s_q;
`ifdef FIR_SAT_EN
    sat_d       = sat_q;
`endif
    if (flush) begin
      x_d  = '0;
      v1_d = 1'b0;
    end else if (in_valid) begin
      x_d = {x_q[TAPS-2:0], a};
    end
    if (v1_q) begin
`ifdef FIR_SAT_EN
      s_d   = SW'(rnd.val);
      sat_d = rnd.sat;
`else
      s_d   = sum;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
`ifdef FIR_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      x_q         <= x_d;
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
`ifdef FIR_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
`ifdef FIR_SAT_EN
  assign sat       = sat_q;
`else
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_ntap_prog.sv
// Scoreboard bench for fir_ntap_prog: directed vectors push expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_fir_ntap_prog;
  import fir_pkg::*;

  localparam int W    = FIR_W;
  localparam int TAPS = FIR_TAPS;
  localparam int CW   = FIR_CW;
  localparam int IW   = $clog2(TAPS);
  localparam int SW   = sw_calc(W, CW, TAPS);

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic                 in_valid;
  logic [W-1:0]         a;
  logic                 coef_we;
  logic [IW-1:0]        coef_idx;
  logic [CW-1:0]        coef_data;
  logic                 coef_commit;
  logic                 out_valid;
  logic signed [SW-1:0] s;
  logic                 sat;

  fir_ntap_prog #(.w(W), .TAPS(TAPS), .CW(CW), .SHIFT(FIR_SHIFT)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .a           (a),
    .coef_we     (coef_we),
    .coef_idx    (coef_idx),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .out_valid   (out_valid),
    .s           (s),
    .sat         (sat)
  );

  typedef struct {
    logic signed [63:0] s;
    logic               sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got s=%0d, expected no output", s);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("s", s, e.s);
        check("sat", sat, e.sat);
      end
    end
  end

  task automatic push(input logic signed [63:0] v, input logic st = 1'b0);
    exp_t e;
    e.s   = v;
    e.sat = st;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic signed [W-1:0] v);
    a        = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic set_coef(input int idx, input logic signed [CW-1:0] v,
                          input logic cm);
    coef_we     = 1'b1;
    coef_idx    = IW'(idx);
    coef_data   = v;
    coef_commit = cm;
    @(posedge clk);
    #1;
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic set_all(input logic signed [CW-1:0] v);
    for (int k = 0; k < TAPS; k++) set_coef(k, v, k == TAPS - 1);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    coef_we     = 1'b0;
    coef_idx    = '0;
    coef_data   = '0;
    coef_commit = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_s", s, 0);
    check("reset_sat", sat, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

`ifndef FIR_SAT_EN
    // Reset coefficients: running 4-sample sum, two-cycle latency.
    push(1); push(3); push(6); push(10); push(14);
    send(1);
    check("latency_n1_valid", out_valid, 0);
    send(2);
    check("latency_n2_valid", out_valid, 1);
    check("latency_n2_s", s, 1);
    send(3); send(4); send(5);
    idle(4);
    do_flush();

    // Gapped input: s holds and out_valid stays low during gaps.
    push(1); push(3); push(6);
    send(1);
    idle(1);
    send(2);
    check("gap1_valid", out_valid, 0);
    check("gap1_hold", s, 1);
    idle(1);
    send(3);
    check("gap2_valid", out_valid, 0);
    check("gap2_hold", s, 3);
    idle(4);

    // Flush clears the line; a sample coincident with flush is dropped.
    do_flush();
    push(7); push(14);
    send(7); send(7);
    idle(4);
    flush    = 1'b1;
    in_valid = 1'b1;
    a        = W'(100);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    push(1);
    send(1);
    idle(4);

    // Programmed coefficients, last write committed in the same cycle.
    set_coef(0, 2, 1'b0);
    set_coef(1, -1, 1'b0);
    set_coef(2, 0, 1'b0);
    set_coef(3, 3, 1'b1);
    do_flush();
    push(2); push(-1); push(0); push(3); push(0);
    send(1); send(0); send(0); send(0); send(0);
    idle(4);

    // Extremes: full-precision sum reaches 2^32 without wrapping.
    set_all(-32768);
    do_flush();
    push(64'sd1 <<< 30); push(64'sd1 <<< 31); push(64'sd3 <<< 30); push(64'sd1 <<< 32);
    send(-32768); send(-32768); send(-32768); send(-32768);
    idle(4);

    // Async reset mid-stream: in-flight sample lost, coefficients back to 1.
    send(5);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid", out_valid, 0);
    check("midreset_s", s, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    push(1); push(3);
    send(1); send(2);
    idle(4);
`else
    // Unity coefficients, shift 2 with round-half-up, no clamping.
    push(8192); push(16384); push(24575); push(32767);
    send(32767); send(32767); send(32767); send(32767);
    idle(4);
    do_flush();

    // Gain 4 drives the result past the positive limit.
    set_all(4);
    do_flush();
    push(32767, 1'b0); push(32767, 1'b1); push(32767, 1'b1); push(32767, 1'b1);
    send(32767); send(32767); send(32767); send(32767);
    idle(4);
    do_flush();

    // Gain 4 with negative full-scale input clamps at the negative limit.
    push(-32768, 1'b0); push(-32768, 1'b1); push(-32768, 1'b1); push(-32768, 1'b1);
    send(-32768); send(-32768); send(-32768); send(-32768);
    idle(4);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
